// File: rtl/enigma_pkg.sv
// Shared wiring tables, notches and mod-26 helpers
// for the enigma stream core.
package enigma_pkg;

  localparam int ALPHA = 26;

  typedef logic [4:0] ltr_t;

  localparam ltr_t ROTOR_FWD [5][26] = '{
    '{4, 10, 12, 5, 11, 6, 3, 16, 21, 25, 13, 19, 14,
      22, 24, 7, 23, 20, 18, 15, 0, 8, 1, 17, 2, 9},
    '{0, 9, 3, 10, 18, 8, 17, 20, 23, 1, 11, 7, 22,
      19, 12, 2, 16, 6, 25, 13, 15, 24, 5, 21, 14, 4},
    '{1, 3, 5, 7, 9, 11, 2, 15, 17, 19, 23, 21, 25,
      13, 24, 4, 8, 22, 6, 0, 10, 12, 20, 18, 16, 14},
    '{4, 18, 14, 21, 15, 25, 9, 0, 24, 16, 20, 8, 17,
      7, 23, 11, 13, 5, 19, 6, 10, 3, 2, 12, 22, 1},
    '{21, 25, 1, 17, 6, 8, 19, 24, 20, 15, 18, 3, 13,
      7, 11, 23, 0, 22, 12, 9, 16, 14, 5, 4, 2, 10}
  };

  localparam ltr_t ROTOR_INV [5][26] = '{
    '{20, 22, 24, 6, 0, 3, 5, 15, 21, 25, 1, 4, 2,
      10, 12, 19, 7, 23, 18, 11, 17, 8, 13, 16, 14, 9},
    '{0, 9, 15, 2, 25, 22, 17, 11, 5, 1, 3, 10, 14,
      19, 24, 20, 16, 6, 4, 13, 7, 23, 12, 8, 21, 18},
    '{19, 0, 6, 1, 15, 2, 18, 3, 16, 4, 20, 5, 21,
      13, 25, 7, 24, 8, 23, 9, 22, 11, 17, 10, 14, 12},
    '{7, 25, 22, 21, 0, 17, 19, 13, 11, 6, 20, 15, 23,
      16, 2, 4, 9, 12, 1, 18, 10, 3, 24, 14, 8, 5},
    '{16, 2, 24, 11, 23, 22, 4, 13, 5, 19, 25, 14, 18,
      12, 21, 9, 20, 3, 10, 6, 8, 0, 17, 15, 7, 1}
  };

  localparam ltr_t ROTOR_NOTCH [5] = '{16, 4, 21, 9, 25};

  localparam ltr_t REFL [3][26] = '{
    '{4, 9, 12, 25, 0, 11, 24, 23, 21, 1, 22, 5, 2,
      17, 16, 20, 14, 13, 19, 18, 15, 8, 10, 7, 6, 3},
    '{24, 17, 20, 7, 16, 18, 11, 3, 15, 23, 13, 6, 14,
      10, 12, 8, 4, 1, 5, 25, 2, 22, 21, 9, 0, 19},
    '{5, 21, 15, 9, 8, 0, 14, 24, 4, 3, 17, 25, 23,
      22, 6, 2, 19, 10, 20, 16, 18, 1, 13, 12, 11, 7}
  };

  // Must stay an involution: the same map undoes itself on the way out.
  localparam ltr_t PLUG_MAP [26] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12,
    13, 14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25
  };

  function automatic ltr_t add26(ltr_t a, ltr_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic ltr_t sub26(ltr_t a, ltr_t b);
    logic [5:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + 6'd26;
    return s[4:0];
  endfunction

  function automatic ltr_t inc26(ltr_t a);
    return (a == 5'd25) ? 5'd0 : a + 5'd1;
  endfunction

endpackage

// File: rtl/enigma_rotor_slot.sv
// One rotor pass, forward or inverse wiring,
// offset by the rotor position.
module enigma_rotor_slot
  import enigma_pkg::*;
(
  input  logic [4:0] pos,
  input  logic [2:0] wiring,
  input  logic [4:0] letter,
  input  logic       dir,
  output logic [4:0] result
);

  logic [2:0] wi;
  ltr_t       idx;
  ltr_t       tap;

  always_comb begin
    wi     = (wiring > 3'd4) ? 3'd0 : wiring;
    idx    = add26(letter, pos);
    tap    = dir ? ROTOR_INV[wi][idx]
                 : ROTOR_FWD[wi][idx];
    result = sub26(tap, pos);
  end

endmodule

// File: rtl/enigma_stream_core.sv
// Streaming enigma: plugboard, stepping rotors,
// reflector, registered valid/ready output.
module enigma_stream_core
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3,
  parameter int W          = 5,
  parameter logic [3*NUM_ROTORS-1:0] ROTOR_SEL = 9'b000_001_010,
  parameter int REFL_SEL   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_load,
  input  logic [NUM_ROTORS*W-1:0] cfg_pos,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_letter,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_letter,
  output logic [NUM_ROTORS*W-1:0] rotor_pos
);

  logic [NUM_ROTORS-1:0][W-1:0] pos_q;
  logic [NUM_ROTORS-1:0][W-1:0] pos_nxt;
  logic [NUM_ROTORS-1:0][W-1:0] load_pos;
  logic [NUM_ROTORS-1:0]        at_notch;
  logic [NUM_ROTORS-1:0]        step;

  logic is_letter;
  logic accept;
  ltr_t x;
  ltr_t pb_in;
  ltr_t refl_in;
  ltr_t refl_out;
  ltr_t rev_out;
  ltr_t enc;

  assign in_ready  = !cfg_load && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign rotor_pos = pos_q;

  assign is_letter = (in_letter != '0) && (in_letter <= 5'd26);
  assign x         = is_letter ? in_letter - 5'd1 : '0;
  assign pb_in     = PLUG_MAP[x];

  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_slot
    localparam logic [2:0] WI = ROTOR_SEL[3*g+:3];

    ltr_t f_in;
    ltr_t f_out;
    ltr_t r_in;
    ltr_t r_out;

    assign at_notch[g] = pos_q[g] == ROTOR_NOTCH[WI];

    // Middle slots also step on their own notch (double-step).
    if (g == 0) begin : g_fast
      assign step[g] = 1'b1;
    end else if (g <= NUM_ROTORS - 2) begin : g_mid
      assign step[g] = at_notch[g-1] | at_notch[g];
    end else begin : g_left
      assign step[g] = at_notch[g-1];
    end

    assign pos_nxt[g] = step[g] ? inc26(pos_q[g]) : pos_q[g];

    if (g == 0) begin : g_fin
      assign f_in = pb_in;
    end else begin : g_fchain
      assign f_in = g_slot[g-1].f_out;
    end

    if (g == NUM_ROTORS - 1) begin : g_rin
      assign r_in = refl_out;
    end else begin : g_rchain
      assign r_in = g_slot[g+1].r_out;
    end

    enigma_rotor_slot u_fwd (
      .pos    (pos_nxt[g]),
      .wiring (WI),
      .letter (f_in),
      .dir    (1'b0),
      .result (f_out)
    );

    enigma_rotor_slot u_rev (
      .pos    (pos_nxt[g]),
      .wiring (WI),
      .letter (r_in),
      .dir    (1'b1),
      .result (r_out)
    );
  end

  assign refl_in  = g_slot[NUM_ROTORS-1].f_out;
  assign refl_out = REFL[REFL_SEL][refl_in];
  assign rev_out  = g_slot[0].r_out;
  assign enc      = PLUG_MAP[rev_out] + 5'd1;

  always_comb begin
    load_pos = '0;
    for (int s = 0; s < NUM_ROTORS; s++) begin
      load_pos[s] = (cfg_pos[W*s+:W] > 5'd25)
                  ? cfg_pos[W*s+:W] - 5'd26
                  : cfg_pos[W*s+:W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= '0;
      out_valid  <= 1'b0;
      out_letter <= '0;
    end else if (cfg_load) begin
      pos_q     <= load_pos;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_letter <= is_letter ? enc : in_letter;
      if (is_letter) pos_q <= pos_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enigma_stream_core.sv
// Directed bench for enigma_stream_core with a
// letter-table reference model checked every cycle.
module tb_enigma_stream_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_load = 1'b0;
  logic [14:0] cfg_pos = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_letter = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_letter;
  logic [14:0] rotor_pos;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  enigma_stream_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_load   (cfg_load),
    .cfg_pos    (cfg_pos),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_letter  (in_letter),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_letter (out_letter),
    .rotor_pos  (rotor_pos)
  );

  string WIR [5] = '{
    "EKMFLGDQVZNTOWYHXUSPAIBRCJ",
    "AJDKSIRUXBLHWTMCQGZNPYFVOE",
    "BDFHJLCPRTXVZNYEIWGAKMUSQO",
    "ESOVPZJAYQUIRHXLNFTGKDCMWB",
    "VZBRGITYUPSDNHLXAWMJQOFECK"
  };
  string REFB = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  int NOTCH [5] = '{16, 4, 21, 9, 25};
  int SEL [3] = '{2, 1, 0};

  int mp [3];
  bit mv;
  int ml;
  int got [$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int m26(int v);
    return ((v % 26) + 26) % 26;
  endfunction

  function automatic int fw(int w, int i);
    return int'(WIR[w][i]) - 65;
  endfunction

  function automatic int bw(int w, int c);
    for (int j = 0; j < 26; j++)
      if (fw(w, j) == c) return j;
    return 0;
  endfunction

  function automatic int packpos();
    return mp[0] + 32 * mp[1] + 1024 * mp[2];
  endfunction

  task automatic model_accept(int l);
    bit n0, n1;
    int xv;
    if (l < 1 || l > 26) begin
      ml = l;
    end else begin
      n0 = mp[0] == NOTCH[SEL[0]];
      n1 = mp[1] == NOTCH[SEL[1]];
      if (n1) mp[2] = (mp[2] + 1) % 26;
      if (n0 || n1) mp[1] = (mp[1] + 1) % 26;
      mp[0] = (mp[0] + 1) % 26;
      xv = l - 1;
      for (int s = 0; s < 3; s++)
        xv = m26(fw(SEL[s], m26(xv + mp[s])) - mp[s]);
      xv = int'(REFB[xv]) - 65;
      for (int s = 2; s >= 0; s--)
        xv = m26(bw(SEL[s], m26(xv + mp[s])) - mp[s]);
      ml = xv + 1;
    end
    mv = 1'b1;
  endtask

  initial begin
    int c;
    mp = '{0, 0, 0};
    mv = 1'b0;
    ml = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mp = '{0, 0, 0};
        mv = 1'b0;
        ml = 0;
      end
      chk("out_valid", int'(out_valid), int'(mv));
      if (mv) chk("out_letter", int'(out_letter), ml);
      chk("rotor_pos", int'(rotor_pos), packpos());
      chk("in_ready", int'(in_ready),
          int'(!cfg_load && (!mv || out_ready)));
      if (rst_n) begin
        if (cfg_load) begin
          for (int s = 0; s < 3; s++) begin
            c = int'(cfg_pos[5*s+:5]);
            mp[s] = (c > 25) ? c - 26 : c;
          end
          mv = 1'b0;
        end else if (in_valid && (!mv || out_ready)) begin
          model_accept(int'(in_letter));
        end else if (out_ready) begin
          mv = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready)
        got.push_back(int'(out_letter));
    end
  end

  task automatic send(int l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_letter = l[4:0];
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: letter %0d not accepted", l);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load(int p);
    cfg_pos = p[14:0];
    cfg_load = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic int got_at(int i);
    return (i < got.size()) ? got[i] : -1;
  endfunction

  int e1 [5] = '{2, 4, 26, 7, 15};
  int e4 [3] = '{2, 4, 26};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_letter", int'(out_letter), 0);
    chk("rst_rotor_pos", int'(rotor_pos), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    load(0);
    got.delete();
    for (int i = 0; i < 5; i++) send(1);
    drain();
    chk("t1_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("t1_bdzgo", got_at(i), e1[i]);
    chk("t1_rotor", int'(rotor_pos), 5);

    load(0);
    got.delete();
    for (int i = 0; i < 5; i++) send(e1[i]);
    drain();
    chk("t2_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_recip", got_at(i), 1);

    load(116);
    send(1);
    chk("t3_adv", int'(rotor_pos), 117);
    send(1);
    chk("t3_aew", int'(rotor_pos), 150);
    send(1);
    chk("t3_bfx", int'(rotor_pos), 1207);
    drain();

    load(0);
    got.delete();
    out_ready = 1'b0;
    send(1);
    in_valid = 1'b1;
    in_letter = 5'd1;
    repeat (4) begin
      @(negedge clk);
      chk("t4_in_ready", int'(in_ready), 0);
      chk("t4_held_valid", int'(out_valid), 1);
      chk("t4_held_letter", int'(out_letter), 2);
      chk("t4_no_step", int'(rotor_pos), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(1);
    send(1);
    drain();
    chk("t4_count", got.size(), 3);
    for (int i = 0; i < 3; i++) chk("t4_stream", got_at(i), e4[i]);
    chk("t4_rotor", int'(rotor_pos), 3);

    got.delete();
    send(0);
    send(27);
    drain();
    chk("t5_count", got.size(), 2);
    chk("t5_zero", got_at(0), 0);
    chk("t5_27", got_at(1), 27);
    chk("t5_rotor", int'(rotor_pos), 3);

    out_ready = 1'b0;
    send(5);
    in_valid = 1'b1;
    in_letter = 5'd6;
    cfg_pos = 15'd30;
    cfg_load = 1'b1;
    @(negedge clk);
    chk("t6_load_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    chk("t6_flush", int'(out_valid), 0);
    chk("t6_wrap_load", int'(rotor_pos), 4);

    out_ready = 1'b1;
    got.delete();
    send(1);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(out_valid), 0);
    chk("t6_async_pos", int'(rotor_pos), 0);
    chk("t6_async_letter", int'(out_letter), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("t6_lost", got.size(), 0);
    send(1);
    drain();
    chk("t6_restart_cnt", got.size(), 1);
    chk("t6_restart", got_at(0), 2);
    chk("t6_restart_pos", int'(rotor_pos), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
